// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection and EX operand forwarding for a 5-stage pipeline.
// Optional stall-cycle counter on stall_cnt_o is built when HFU_STALL_CNT_EN is defined.
module hazard_forward_unit (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rt_i,
  input  logic [4:0] id_dest_i,
  input  logic       id_regwrite_i,
  input  logic       id_memread_i,
  input  logic       flush_i,
  output logic [1:0] forward_1_o,
  output logic [1:0] forward_2_o,
  output logic       stall_o
`ifdef HFU_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt_o
`endif
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       regwrite;
    logic       memread;
  } stage_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam stage_t BUBBLE = '{valid: 1'b0, dest: 5'd0, regwrite: 1'b0, memread: 1'b0};

  state_t r_state;
  state_t w_state_nxt;
  stage_t r_ex;
  stage_t r_mem;
  stage_t r_wb;
  stage_t w_id;
  logic   w_hazard;
  logic   w_advance;
  logic   w_stall;
  logic [1:0] w_fwd_1;
  logic [1:0] w_fwd_2;
  logic   w_unused;

  // EX-stage match wins over MEM; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(input stage_t ex, input stage_t mem,
                                         input logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex.valid && ex.regwrite && (ex.dest != 5'd0) && (ex.dest == src)) begin
      sel = FWD_MEM;
    end else if (mem.valid && mem.regwrite && (mem.dest != 5'd0) && (mem.dest == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign w_id = '{valid: id_valid_i, dest: id_dest_i,
                  regwrite: id_regwrite_i, memread: id_memread_i};

  assign w_hazard = id_valid_i && r_ex.valid && r_ex.memread && (r_ex.dest != 5'd0) &&
                    ((r_ex.dest == id_rs_i) || (id_use_rt_i && (r_ex.dest == id_rt_i)));

  assign w_fwd_1 = fwd_sel(r_ex, r_mem, id_rs_i);
  assign w_fwd_2 = fwd_sel(r_ex, r_mem, id_rt_i);

  // stall_o is combinational so PC and IF/ID freeze in the same cycle the hazard appears.
  always_comb begin
    w_stall     = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        w_stall = w_hazard & ~flush_i;
        if (w_stall) begin
          w_state_nxt = ST_STALL;
        end
      end
      ST_STALL: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign stall_o   = w_stall;
  assign w_advance = ~w_stall & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stall or flush inserts a bubble into EX while older stages keep draining.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ex  <= BUBBLE;
      r_mem <= BUBBLE;
      r_wb  <= BUBBLE;
    end else begin
      r_ex  <= w_advance ? w_id : BUBBLE;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      forward_1_o <= FWD_RF;
      forward_2_o <= FWD_RF;
    end else if (w_advance) begin
      forward_1_o <= w_fwd_1;
      forward_2_o <= w_fwd_2;
    end else begin
      forward_1_o <= FWD_RF;
      forward_2_o <= FWD_RF;
    end
  end

`ifdef HFU_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= 16'd0;
    end else if (w_stall && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

  // WB shadow is kept for pipeline-state observation only; nothing forwards from it.
  assign w_unused = ^r_wb;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding codes, load-use stall, flush and reset.
// Counter checks are compiled in when HFU_STALL_CNT_EN is defined.
module tb_hazard_forward_unit;

  logic       clk_i;
  logic       rst_i;
  logic       id_valid_i;
  logic [4:0] id_rs_i;
  logic [4:0] id_rt_i;
  logic       id_use_rt_i;
  logic [4:0] id_dest_i;
  logic       id_regwrite_i;
  logic       id_memread_i;
  logic       flush_i;
  logic [1:0] forward_1_o;
  logic [1:0] forward_2_o;
  logic       stall_o;
`ifdef HFU_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hazard_forward_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_use_rt_i  (id_use_rt_i),
    .id_dest_i    (id_dest_i),
    .id_regwrite_i(id_regwrite_i),
    .id_memread_i (id_memread_i),
    .flush_i      (flush_i),
    .forward_1_o  (forward_1_o),
    .forward_2_o  (forward_2_o),
    .stall_o      (stall_o)
`ifdef HFU_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic use_rt, input logic [4:0] dest, input logic rw,
                       input logic mr, input logic fl);
    id_valid_i    = v;
    id_rs_i       = rs;
    id_rt_i       = rt;
    id_use_rt_i   = use_rt;
    id_dest_i     = dest;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    flush_i       = fl;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_fwd(input string tag, input logic [1:0] e1, input logic [1:0] e2);
    check_eq({tag, "_f1"}, 16'(forward_1_o), 16'(e1));
    check_eq({tag, "_f2"}, 16'(forward_2_o), 16'(e2));
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp);
`ifdef HFU_STALL_CNT_EN
    check_eq(tag, stall_cnt_o, exp);
`else
    if (exp == 16'hFFFF) $display("unexpected counter target for %s", tag);
`endif
  endtask

  initial begin
    rst_i = 1'b0;
    nop();
    #2;
    check_eq("rst_stall", 16'(stall_o), 16'd0);
    check_fwd("rst", 2'b00, 2'b00);
    check_eq("rst_state", 16'(dut.r_state), 16'd0);
    check_cnt("rst_cnt", 16'd0);
    tick();
    tick();
    rst_i = 1'b1;
    tick();

    // add $3,$1,$2 ; sub $5,$3,$4
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    check_fwd("add_ex", 2'b00, 2'b00);
    drive(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("sub_nostall", 16'(stall_o), 16'd0);
    tick();
    check_fwd("sub_ex", 2'b01, 2'b00);

    // add $3 ; nop ; or $6,$7,$3
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    drive(1'b1, 5'd7, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    check_fwd("or_ex", 2'b00, 2'b10);

    // lw $8,0($9) ; add $10,$8,$8
    drive(1'b1, 5'd9, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd8, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("lu_stall", 16'(stall_o), 16'd1);
    tick();
    check_eq("lu_stall_drop", 16'(stall_o), 16'd0);
    check_eq("lu_state_stall", 16'(dut.r_state), 16'd1);
    check_fwd("lu_bubble", 2'b00, 2'b00);
    tick();
    check_fwd("lu_add_ex", 2'b10, 2'b10);
    check_eq("lu_state_run", 16'(dut.r_state), 16'd0);
    check_cnt("lu_cnt", 16'd1);

    // two writers of $4, consumer reads $4 twice
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd4, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    check_fwd("dual_wr", 2'b01, 2'b01);

    // $0 writer and $0 load never match or stall
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    check_fwd("r0_wr", 2'b00, 2'b00);
    drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("r0_lw_nostall", 16'(stall_o), 16'd0);
    tick();

    // load-use with flush: no stall, bubble; following reader gets WB with no stall
    drive(1'b1, 5'd9, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b1);
    #1;
    check_eq("fl_nostall", 16'(stall_o), 16'd0);
    tick();
    check_fwd("fl_bubble", 2'b00, 2'b00);
    check_eq("fl_state", 16'(dut.r_state), 16'd0);
    drive(1'b1, 5'd8, 5'd1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("fl_after_nostall", 16'(stall_o), 16'd0);
    tick();
    check_fwd("fl_after", 2'b10, 2'b00);
    check_cnt("fl_cnt", 16'd1);

    // back-to-back load/use pairs, one stall each
    drive(1'b1, 5'd9, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd2, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("b2b_s1", 16'(stall_o), 16'd1);
    tick();
    check_eq("b2b_s1_end", 16'(stall_o), 16'd0);
    tick();
    drive(1'b1, 5'd2, 5'd9, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    #1;
    check_eq("b2b_lw2_nostall", 16'(stall_o), 16'd0);
    tick();
    drive(1'b1, 5'd3, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("b2b_s2", 16'(stall_o), 16'd1);
    tick();
    check_eq("b2b_s2_end", 16'(stall_o), 16'd0);
    tick();
    check_fwd("b2b_add2", 2'b00, 2'b10);
    check_cnt("b2b_cnt", 16'd3);

    // reset asserted while stall_o is high
    drive(1'b1, 5'd9, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd8, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("rs_pre_stall", 16'(stall_o), 16'd1);
    rst_i = 1'b0;
    #1;
    check_eq("rs_stall_drop", 16'(stall_o), 16'd0);
    check_fwd("rs_clr", 2'b00, 2'b00);
    check_eq("rs_state", 16'(dut.r_state), 16'd0);
    check_cnt("rs_cnt", 16'd0);
    tick();
    rst_i = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("rs_indep_nostall", 16'(stall_o), 16'd0);
    tick();
    check_fwd("rs_indep", 2'b00, 2'b00);
    check_eq("rs_state_run", 16'(dut.r_state), 16'd0);

    nop();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk_i and rst_i as elsewhere in the codebase.
REQ-002 Ports SHALL be:
- clk_i  in  1  clock
- rst_i  in  1  async active-low reset
- id_valid_i  in  1  ID stage holds a real instruction
- id_rs_i  in  5  ID source register 1
- id_rt_i  in  5  ID source register 2
- id_use_rt_i  in  1  ID instruction reads rt as an ALU operand; used only for the load-use check
- id_dest_i  in  5  ID destination register, already resolved rt/rd
- id_regwrite_i  in  1  ID instruction writes the register file
- id_memread_i  in  1  ID instruction is a load
- flush_i  in  1  taken branch; squash the ID instruction
- forward_1_o  out  2  EX operand-1 select
- forward_2_o  out  2  EX operand-2 select
- stall_o  out  1  hold PC and IF/ID, insert a bubble into EX
- stall_cnt_o  out  16  stall-cycle count; present only with HFU_STALL_CNT_EN

Function
REQ-003 Forward select encoding SHALL be:
- 00: register-file value
- 01: previous-cycle ALU result (EX/MEM)
- 10: WB write-back value
- 11: never driven
REQ-004 The block SHALL hold shadow stage registers ex_q, mem_q and wb_q, each holding {valid, dest[4:0], regwrite, memread}.
REQ-005 On each clock edge, when stall_o=0 and flush_i=0, the ID fields SHALL be loaded into ex_q, and ex_q SHALL shift to mem_q and mem_q to wb_q.
REQ-006 When stall_o=1 or flush_i=1, ex_q SHALL load a bubble (valid=0) and mem_q/wb_q SHALL still shift.
REQ-007 The operand-1 code SHALL be 01 if ex_q is valid, has regwrite=1 and dest!=0, and dest equals id_rs_i.
REQ-008 Otherwise the operand-1 code SHALL be 10 if mem_q meets the same condition; otherwise 00.
REQ-009 Operand 2 SHALL use the same rule with id_rt_i; EX-stage priority SHALL win when both match.
REQ-010 forward_1_o and forward_2_o SHALL be registered and updated only on edges that advance ID into EX.
REQ-011 On bubble edges (stall or flush) forward_1_o and forward_2_o SHALL load 00.
REQ-012 A load-use hazard SHALL be raised when ex_q is valid with memread=1 and dest!=0, and dest equals id_rs_i, or dest equals id_rt_i with id_use_rt_i=1.
REQ-013 The hazard SHALL be evaluated only when id_valid_i=1.
REQ-014 The FSM SHALL have two states, RUN and STALL, and SHALL reset to RUN.
REQ-015 In RUN, stall_o SHALL be driven combinationally: hazard & ~flush_i.
REQ-016 RUN SHALL go to STALL when stall_o=1; otherwise it SHALL stay in RUN.
REQ-017 In STALL, stall_o SHALL be 0, the re-presented instruction SHALL advance, and the state SHALL return to RUN unconditionally.
REQ-018 After one stall, the load sits in mem_q, so the consumer SHALL receive code 10.
REQ-019 flush_i SHALL take priority over the hazard: no stall, a bubble into ex_q, and FSM to RUN.
REQ-020 Register 0 SHALL never match and SHALL never stall.
REQ-021 Back-to-back loads, each followed by a dependent instruction, SHALL each cost exactly one stall cycle.

Reset
REQ-022 While rst_i=0, the following SHALL be cleared asynchronously: ex_q/mem_q/wb_q valid=0, FSM=RUN, forward_1_o=00, forward_2_o=00, stall_o=0, stall_cnt_o=0.
REQ-023 A reset asserted mid-stall SHALL drop stall_o within the same cycle, and the unit SHALL resume in RUN with no stale forwarding.

Configuration
REQ-024 When HFU_STALL_CNT_EN is defined, stall_cnt_o SHALL increment on every edge with stall_o=1, saturate at 16'hFFFF, and clear only on reset.
REQ-025 When HFU_STALL_CNT_EN is undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-026 add $3,$1,$2 then sub $5,$3,$4, back-to-back -> sub in EX sees forward_1_o=01, forward_2_o=00, no stall.
REQ-027 add $3 ; nop ; or $6,$7,$3 -> forward_2_o=10 when or enters EX.
REQ-028 lw $8,0($9) then add $10,$8,$8 (use_rt=1) -> stall_o=1 for exactly 1 cycle, then add enters EX with forward_1_o=forward_2_o=10; stall_cnt_o=1 with HFU_STALL_CNT_EN.
REQ-029 Both stages writing $4 (EX and MEM), consumer reads $4 -> 01 chosen; dest=$0 writer with consumer reading $0 -> 00, no stall.
REQ-030 Load-use hazard present together with flush_i=1 -> stall_o=0, ex_q bubble, next forward codes 00.
REQ-031 rst_i low during STALL -> stall_o=0 immediately; after release, an independent instruction yields codes 00 and FSM in RUN.
